shell_hit_detector: RTL and testbench



---
 rtl/tank_pkg.sv | 38 +++
 rtl/hit_counter.sv | 20 ++
 rtl/shell_hit_detector.sv | 121 ++++++++++++
 tb/tb_shell_hit_detector.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared types and constants for the tank game datapath.
//   coord_t      : 6-bit cell coordinate
//   dir_t        : movement direction
//   MAP_*_DEF    : default playfield size
//   NUM_SHELLS   : shells per tank; slots 0..4 belong to tank 1, 5..9 to tank 2
//   eval_t       : one scan slot as carried from ISSUE into EVAL
package tank_pkg;
  typedef logic [5:0] coord_t;

  typedef enum logic [2:0] {
    UP    = 3'd0,
    DOWN  = 3'd1,
    LEFT  = 3'd2,
    RIGHT = 3'd3,
    STAND = 3'd4
  } dir_t;

  localparam int MAP_W_DEF   = 40;
  localparam int MAP_H_DEF   = 30;
  localparam int HIT_MAX_DEF = 7;
  localparam int NUM_SHELLS  = 5;
  localparam int NUM_SLOTS   = 2 * NUM_SHELLS;

  typedef logic [6*NUM_SHELLS-1:0] shell_pos_t;

  typedef struct packed {
    logic       t2;   // owner is tank 2
    logic [2:0] k;    // shell number within owner
    logic [3:0] idx;  // global slot 0..9
    coord_t     x;
    coord_t     y;
  } eval_t;

  // Shell k of a packed position bus lives at [6k+5:6k].
  function automatic coord_t shell_coord(input shell_pos_t v, input logic [2:0] k);
    return v[6*k +: 6];
  endfunction
endpackage

// File: rtl/hit_counter.sv
// Saturating hit counter.
//   clk, rst : clock, async active-high reset
//   inc      : count one hit this cycle
//   count    : running total, sticks at MAX
module hit_counter
  import tank_pkg::*;
#(
  parameter int MAX = HIT_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [2:0] count
);
  localparam logic [2:0] MAX_C = 3'(MAX);

  always_ff @(posedge clk or posedge rst)
    if (rst)                         count <= '0;
    else if (inc && (count != MAX_C)) count <= count + 3'd1;
endmodule

// File: rtl/shell_hit_detector.sv
// Round-robin shell collision checker.
//   ISSUE: one slot per enabled cycle, wall-map address driven from its position.
//   EVAL : next cycle, wall data returns; decide out-of-bounds > wall > tank.
//   OUT  : registered one-cycle vanish / hit pulses, two cycles after issue.
// Ports:
//   clk, rst                 clock, async active-high reset
//   enable                   scan enable; low flushes EVAL and freezes idx
//   shell_{1,2}_{x,y}_pos    packed shell positions, valid_{1,2}_shell (1 = idle)
//   tank_{1,2}_{x,y}_pos     tank cells
//   wall_rd_x/y, wall_rd_data  wall map, data one cycle after address
//   vanish_{1,2}             per-shell vanish pulse
//   hit_{1,2}, hit_count_{1,2}  tank struck pulse and saturating totals
module shell_hit_detector
  import tank_pkg::*;
#(
  parameter int MAP_W   = MAP_W_DEF,
  parameter int MAP_H   = MAP_H_DEF,
  parameter int HIT_MAX = HIT_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [29:0] shell_1_x_pos,
  input  logic [29:0] shell_1_y_pos,
  input  logic [29:0] shell_2_x_pos,
  input  logic [29:0] shell_2_y_pos,
  input  logic [4:0]  valid_1_shell,
  input  logic [4:0]  valid_2_shell,
  input  logic [5:0]  tank_1_x_pos,
  input  logic [5:0]  tank_1_y_pos,
  input  logic [5:0]  tank_2_x_pos,
  input  logic [5:0]  tank_2_y_pos,
  output logic [5:0]  wall_rd_x,
  output logic [5:0]  wall_rd_y,
  input  logic        wall_rd_data,
  output logic [4:0]  vanish_1,
  output logic [4:0]  vanish_2,
  output logic        hit_1,
  output logic        hit_2,
  output logic [2:0]  hit_count_1,
  output logic [2:0]  hit_count_2
);
  localparam coord_t MW = coord_t'(MAP_W);
  localparam coord_t MH = coord_t'(MAP_H);

  logic [3:0]           idx;
  logic [3:0]           idx_m5;
  eval_t                iss, ev;
  logic                 ev_vld;
  logic                 iss_idle, ev_idle;
  logic [NUM_SLOTS-1:0] done;   // slots already vanished this pass
  coord_t               opp_x, opp_y;
  logic                 go, oob, wall, tank, van, tank_hit;
  logic [4:0]           oh;

  // ISSUE: decode slot and fetch its position
  always_comb begin
    idx_m5   = idx - 4'd5;
    iss.idx  = idx;
    iss.t2   = (idx >= 4'd5);
    iss.k    = iss.t2 ? idx_m5[2:0] : idx[2:0];
    iss.x    = iss.t2 ? shell_coord(shell_2_x_pos, iss.k) : shell_coord(shell_1_x_pos, iss.k);
    iss.y    = iss.t2 ? shell_coord(shell_2_y_pos, iss.k) : shell_coord(shell_1_y_pos, iss.k);
    iss_idle = iss.t2 ? valid_2_shell[iss.k] : valid_1_shell[iss.k];
  end

  // Address goes out even for out-of-range shells; EVAL ignores that data.
  assign wall_rd_x = rst ? '0 : iss.x;
  assign wall_rd_y = rst ? '0 : iss.y;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx    <= '0;
      ev_vld <= 1'b0;
      ev     <= '0;
    end else if (enable) begin
      idx    <= (idx == 4'd9) ? 4'd0 : idx + 4'd1;
      ev_vld <= !iss_idle;
      ev     <= iss;
    end else begin
      ev_vld <= 1'b0;
    end

  // EVAL: shell may have gone idle since issue, so the live valid bit is rechecked.
  always_comb begin
    ev_idle  = ev.t2 ? valid_2_shell[ev.k] : valid_1_shell[ev.k];
    opp_x    = ev.t2 ? tank_1_x_pos : tank_2_x_pos;
    opp_y    = ev.t2 ? tank_1_y_pos : tank_2_y_pos;
    go       = enable && ev_vld && !ev_idle && !done[ev.idx];
    oob      = (ev.x >= MW) || (ev.y >= MH);
    wall     = !oob && wall_rd_data;
    tank     = !oob && !wall && (ev.x == opp_x) && (ev.y == opp_y);
    van      = go && (oob || wall || tank);
    tank_hit = go && tank;
    oh       = '0;
    oh[ev.k] = van;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vanish_1 <= '0;
      vanish_2 <= '0;
      hit_1    <= 1'b0;
      hit_2    <= 1'b0;
      done     <= '0;
    end else begin
      vanish_1 <= ev.t2 ? 5'd0 : oh;
      vanish_2 <= ev.t2 ? oh : 5'd0;
      hit_1    <= tank_hit && ev.t2;
      hit_2    <= tank_hit && !ev.t2;
      if (enable) done[idx]    <= 1'b0;
      if (van)    done[ev.idx] <= 1'b1;
    end

  hit_counter #(.MAX(HIT_MAX)) u_cnt_1 (
    .clk(clk), .rst(rst), .inc(tank_hit && ev.t2),  .count(hit_count_1)
  );
  hit_counter #(.MAX(HIT_MAX)) u_cnt_2 (
    .clk(clk), .rst(rst), .inc(tank_hit && !ev.t2), .count(hit_count_2)
  );
endmodule

// File: tb/tb_shell_hit_detector.sv
// Directed bench for shell_hit_detector. A small wall RAM answers the
// read port one cycle late; the monitor mimics the shell stage by marking
// a shell idle as soon as its vanish pulse is seen.
module tb_shell_hit_detector;
  logic        clk = 1'b0;
  logic        rst, enable;
  logic [29:0] shell_1_x_pos, shell_1_y_pos, shell_2_x_pos, shell_2_y_pos;
  logic [4:0]  valid_1_shell, valid_2_shell;
  logic [5:0]  tank_1_x_pos, tank_1_y_pos, tank_2_x_pos, tank_2_y_pos;
  logic [5:0]  wall_rd_x, wall_rd_y;
  logic        wall_rd_data;
  logic [4:0]  vanish_1, vanish_2;
  logic        hit_1, hit_2;
  logic [2:0]  hit_count_1, hit_count_2;

  logic [4095:0] wall_mem;

  int errors = 0;
  int checks = 0;
  int v1_cnt, v2_cnt, h1_cnt, h2_cnt, co_cnt, first_v1, first_v2;
  logic [4:0] v1_or, v2_or;

  shell_hit_detector dut (
    .clk(clk), .rst(rst), .enable(enable),
    .shell_1_x_pos(shell_1_x_pos), .shell_1_y_pos(shell_1_y_pos),
    .shell_2_x_pos(shell_2_x_pos), .shell_2_y_pos(shell_2_y_pos),
    .valid_1_shell(valid_1_shell), .valid_2_shell(valid_2_shell),
    .tank_1_x_pos(tank_1_x_pos), .tank_1_y_pos(tank_1_y_pos),
    .tank_2_x_pos(tank_2_x_pos), .tank_2_y_pos(tank_2_y_pos),
    .wall_rd_x(wall_rd_x), .wall_rd_y(wall_rd_y), .wall_rd_data(wall_rd_data),
    .vanish_1(vanish_1), .vanish_2(vanish_2),
    .hit_1(hit_1), .hit_2(hit_2),
    .hit_count_1(hit_count_1), .hit_count_2(hit_count_2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) wall_rd_data <= wall_mem[{wall_rd_y, wall_rd_x}];

  task automatic set_s1(input int k, input logic [5:0] x, input logic [5:0] y);
    shell_1_x_pos[6*k +: 6] = x;
    shell_1_y_pos[6*k +: 6] = y;
  endtask

  task automatic set_s2(input int k, input logic [5:0] x, input logic [5:0] y);
    shell_2_x_pos[6*k +: 6] = x;
    shell_2_y_pos[6*k +: 6] = y;
  endtask

  task automatic set_wall(input logic [5:0] x, input logic [5:0] y);
    wall_mem[{y, x}] = 1'b1;
  endtask

  task automatic defaults();
    enable = 1'b0;
    shell_1_x_pos = '0; shell_1_y_pos = '0;
    shell_2_x_pos = '0; shell_2_y_pos = '0;
    valid_1_shell = '1; valid_2_shell = '1;
    tank_1_x_pos = 6'd20; tank_1_y_pos = 6'd20;
    tank_2_x_pos = 6'd30; tank_2_y_pos = 6'd25;
    wall_mem = '0;
  endtask

  task automatic do_reset();
    defaults();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Collects pulse statistics over n cycles, sampled at the falling edge.
  task automatic run_cycles(input int n);
    v1_cnt = 0; v2_cnt = 0; h1_cnt = 0; h2_cnt = 0; co_cnt = 0;
    first_v1 = -1; first_v2 = -1; v1_or = '0; v2_or = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (vanish_1 != 5'd0) begin
        v1_cnt++; v1_or |= vanish_1;
        if (first_v1 < 0) first_v1 = i;
        valid_1_shell |= vanish_1;
      end
      if (vanish_2 != 5'd0) begin
        v2_cnt++; v2_or |= vanish_2;
        if (first_v2 < 0) first_v2 = i;
        valid_2_shell |= vanish_2;
      end
      if (hit_1) h1_cnt++;
      if (hit_2) h2_cnt++;
      if (vanish_1[4] && hit_2) co_cnt++;
    end
  endtask

  // Bounded wait for a given position to appear on the wall address port.
  task automatic wait_issue(input logic [5:0] x, input logic [5:0] y, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (wall_rd_x == x && wall_rd_y == y) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL %s_issue: slot not issued within 20 cycles", nm); end
  endtask

  task automatic test_reset();
    defaults();
    rst = 1'b1;
    enable = 1'b1;
    set_s1(0, 6'd50, 6'd1); valid_1_shell[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (vanish_1 !== 5'd0) begin errors++; $display("FAIL rst_vanish_1: got %b want 00000", vanish_1); end
    checks++; if (vanish_2 !== 5'd0) begin errors++; $display("FAIL rst_vanish_2: got %b want 00000", vanish_2); end
    checks++; if (hit_1 !== 1'b0) begin errors++; $display("FAIL rst_hit_1: got %b want 0", hit_1); end
    checks++; if (hit_2 !== 1'b0) begin errors++; $display("FAIL rst_hit_2: got %b want 0", hit_2); end
    checks++; if (hit_count_1 !== 3'd0) begin errors++; $display("FAIL rst_count_1: got %0d want 0", hit_count_1); end
    checks++; if (hit_count_2 !== 3'd0) begin errors++; $display("FAIL rst_count_2: got %0d want 0", hit_count_2); end
    checks++; if (wall_rd_x !== 6'd0) begin errors++; $display("FAIL rst_wall_rd_x: got %0d want 0", wall_rd_x); end
    do_reset();
  endtask

  task automatic test_oob();
    do_reset();
    set_s1(2, 6'd40, 6'd10); valid_1_shell[2] = 1'b0;
    enable = 1'b1;
    run_cycles(12);
    checks++; if (v1_cnt !== 1) begin errors++; $display("FAIL oob_x_cycles: got %0d want 1", v1_cnt); end
    checks++; if (v1_or !== 5'b00100) begin errors++; $display("FAIL oob_x_vanish: got %b want 00100", v1_or); end
    checks++; if (h2_cnt !== 0) begin errors++; $display("FAIL oob_x_hit_2: got %0d want 0", h2_cnt); end
    // (39,29) is the last legal cell; y=30 and underflowed x=63 are not
    set_s1(0, 6'd39, 6'd29); valid_1_shell[0] = 1'b0;
    set_s1(1, 6'd0,  6'd30); valid_1_shell[1] = 1'b0;
    set_s1(3, 6'd63, 6'd5);  valid_1_shell[3] = 1'b0;
    run_cycles(12);
    checks++; if (v1_or !== 5'b01010) begin errors++; $display("FAIL oob_edges_vanish: got %b want 01010", v1_or); end
    checks++; if (v1_cnt !== 2) begin errors++; $display("FAIL oob_edges_cycles: got %0d want 2", v1_cnt); end
  endtask

  task automatic test_wall();
    do_reset();
    set_wall(6'd5, 6'd5);
    set_s2(0, 6'd5, 6'd5); valid_2_shell[0] = 1'b0;
    // wall beats tank: shell on tank 2's cell that is also a wall
    tank_2_x_pos = 6'd12; tank_2_y_pos = 6'd8;
    set_wall(6'd12, 6'd8);
    set_s1(1, 6'd12, 6'd8); valid_1_shell[1] = 1'b0;
    enable = 1'b1;
    run_cycles(12);
    checks++; if (v2_cnt !== 1) begin errors++; $display("FAIL wall_cycles: got %0d want 1", v2_cnt); end
    checks++; if (v2_or !== 5'b00001) begin errors++; $display("FAIL wall_vanish_2: got %b want 00001", v2_or); end
    checks++; if (v1_or !== 5'b00010) begin errors++; $display("FAIL wall_prio_vanish_1: got %b want 00010", v1_or); end
    checks++; if (h1_cnt + h2_cnt !== 0) begin errors++; $display("FAIL wall_hits: got %0d want 0", h1_cnt + h2_cnt); end
    checks++; if (hit_count_2 !== 3'd0) begin errors++; $display("FAIL wall_count_2: got %0d want 0", hit_count_2); end
  endtask

  task automatic test_tank_sat();
    logic [2:0] exp_cnt;
    do_reset();
    tank_2_x_pos = 6'd12; tank_2_y_pos = 6'd8;
    set_s1(4, 6'd12, 6'd8);
    enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      valid_1_shell[4] = 1'b0;
      run_cycles(12);
      exp_cnt = (i + 1 > 7) ? 3'd7 : 3'(i + 1);
      checks++; if (co_cnt !== 1 || h2_cnt !== 1) begin errors++; $display("FAIL tank_pulse[%0d]: coincident=%0d hit_2=%0d want 1/1", i, co_cnt, h2_cnt); end
      checks++; if (hit_count_2 !== exp_cnt) begin errors++; $display("FAIL tank_count[%0d]: got %0d want %0d", i, hit_count_2, exp_cnt); end
    end
    checks++; if (hit_count_1 !== 3'd0) begin errors++; $display("FAIL tank_count_1: got %0d want 0", hit_count_1); end
  endtask

  task automatic test_both_hits();
    enable = 1'b0;
    valid_1_shell = '1; valid_2_shell = '1;
    repeat (2) @(posedge clk);
    #1;
    set_s1(1, 6'd12, 6'd8);  valid_1_shell[1] = 1'b0;  // onto tank 2
    set_s2(3, 6'd20, 6'd20); valid_2_shell[3] = 1'b0;  // onto tank 1
    enable = 1'b1;
    run_cycles(12);
    checks++; if (h1_cnt !== 1 || h2_cnt !== 1) begin errors++; $display("FAIL both_pulses: hit_1=%0d hit_2=%0d want 1/1", h1_cnt, h2_cnt); end
    checks++; if (hit_count_1 !== 3'd1) begin errors++; $display("FAIL both_count_1: got %0d want 1", hit_count_1); end
    checks++; if (hit_count_2 !== 3'd7) begin errors++; $display("FAIL both_count_2: got %0d want 7", hit_count_2); end
  endtask

  task automatic test_reset_mid();
    enable = 1'b0;
    valid_1_shell = '1; valid_2_shell = '1;
    shell_1_x_pos = '0; shell_1_y_pos = '0;
    shell_2_x_pos = '0; shell_2_y_pos = '0;
    repeat (2) @(posedge clk);
    #1;
    set_s1(0, 6'd12, 6'd8); valid_1_shell[0] = 1'b0;
    enable = 1'b1;
    wait_issue(6'd12, 6'd8, "rstmid");
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (hit_count_1 !== 3'd0 || hit_count_2 !== 3'd0) begin errors++; $display("FAIL rstmid_counts: got %0d/%0d want 0/0", hit_count_1, hit_count_2); end
    checks++; if (vanish_1 !== 5'd0 || hit_2 !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: vanish_1=%b hit_2=%b want 0", vanish_1, hit_2); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_cycles(12);
    checks++; if (first_v1 !== 2) begin errors++; $display("FAIL rstmid_first_pulse: cycle %0d want 2", first_v1); end
    checks++; if (h2_cnt !== 1 || hit_count_2 !== 3'd1) begin errors++; $display("FAIL rstmid_fresh_hit: pulses=%0d count=%0d want 1/1", h2_cnt, hit_count_2); end
  endtask

  task automatic test_no_self_hit();
    do_reset();
    tank_1_x_pos = 6'd3; tank_1_y_pos = 6'd3;
    set_s1(0, 6'd3, 6'd3);   valid_1_shell = 5'b11110;
    set_s2(0, 6'd30, 6'd25); valid_2_shell = 5'b11110;
    enable = 1'b1;
    run_cycles(30);
    checks++; if (v1_cnt + v2_cnt !== 0) begin errors++; $display("FAIL self_vanish: got %0d want 0", v1_cnt + v2_cnt); end
    checks++; if (h1_cnt + h2_cnt !== 0) begin errors++; $display("FAIL self_hits: got %0d want 0", h1_cnt + h2_cnt); end
    valid_1_shell = '1; valid_2_shell = '1;
    for (int k = 0; k < 5; k++) begin
      set_s1(k, 6'(k + 1), 6'd2); set_wall(6'(k + 1), 6'd2);
      set_s2(k, 6'(k + 1), 6'd9); set_wall(6'(k + 1), 6'd9);
    end
    run_cycles(30);
    checks++; if (v1_cnt + v2_cnt + h1_cnt + h2_cnt !== 0) begin errors++; $display("FAIL idle_on_walls: got %0d pulses want 0", v1_cnt + v2_cnt + h1_cnt + h2_cnt); end
  endtask

  task automatic test_enable();
    do_reset();
    set_s2(2, 6'd50, 6'd5); valid_2_shell[2] = 1'b0;   // slot 7
    enable = 1'b1;
    wait_issue(6'd50, 6'd5, "enable");
    @(posedge clk);
    #1 enable = 1'b0;
    run_cycles(20);
    checks++; if (v2_cnt !== 0) begin errors++; $display("FAIL enable_low_vanish: got %0d want 0", v2_cnt); end
    @(posedge clk);
    #1 enable = 1'b1;
    run_cycles(14);
    // idx held at 8: slots 8,9,0..7 issue, so slot 7 pulses 11 cycles in
    checks++; if (first_v2 !== 11) begin errors++; $display("FAIL enable_resume_cycle: got %0d want 11", first_v2); end
    checks++; if (v2_or !== 5'b00100) begin errors++; $display("FAIL enable_resume_vanish: got %b want 00100", v2_or); end
  endtask

  task automatic test_stale();
    do_reset();
    set_s1(3, 6'd45, 6'd0); valid_1_shell[3] = 1'b0;
    enable = 1'b1;
    wait_issue(6'd45, 6'd0, "stale");
    @(posedge clk);
    #1 valid_1_shell[3] = 1'b1;
    run_cycles(12);
    checks++; if (v1_cnt !== 0) begin errors++; $display("FAIL stale_vanish: got %0d want 0", v1_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    wall_rd_data = 1'b0;
    test_reset();
    test_oob();
    test_wall();
    test_tank_sat();
    test_both_hits();
    test_reset_mid();
    test_no_self_hit();
    test_enable();
    test_stale();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
